// File: rtl/neuron_pkg.sv
// Shared types and width helpers for the neuron controller.
package neuron_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        BIAS,
        OUT
    } state_t;

    function automatic int addr_width(input int num_inputs);
        return $clog2(num_inputs);
    endfunction

    // Sized so that NUM_INPUTS full-scale products can never overflow the sum.
    function automatic int acc_width(input int num_bit, input int num_inputs);
        return 2 * num_bit + $clog2(num_inputs) + 1;
    endfunction

    // One extra bit so the bias add cannot wrap before saturation.
    function automatic int sum_width(input int num_bit, input int num_inputs);
        return acc_width(num_bit, num_inputs) + 1;
    endfunction

endpackage

// File: rtl/neuron_ctrl_if.sv
// Start/fetch/result bundle between the neuron controller and its environment.
interface neuron_ctrl_if
    import neuron_pkg::*;
#(
    parameter int NUM_BIT    = 16,
    parameter int NUM_INPUTS = 4
) ();

    localparam int AW = addr_width(NUM_INPUTS);

    logic                      start;
    logic                      busy;
    logic [AW-1:0]             addr;
    logic signed [NUM_BIT-1:0] x_in;
    logic signed [NUM_BIT-1:0] w_in;
    logic signed [NUM_BIT-1:0] bias;
    logic signed [NUM_BIT-1:0] y;
    logic                      out_valid;
    logic                      out_ready;

    modport master (
        output start, x_in, w_in, bias, out_ready,
        input  busy, addr, y, out_valid
    );

    modport slave (
        input  start, x_in, w_in, bias, out_ready,
        output busy, addr, y, out_valid
    );

endinterface

// File: rtl/Register.sv
// Parameterised enable register with synchronous active-high reset to zero.
module Register #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset)
            q <= '0;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/mac_unit.sv
// Combinational signed multiply-add: acc_next = acc + x * w at full precision.
module mac_unit #(
    parameter int NUM_BIT = 16,
    parameter int ACC_W   = 35
) (
    input  logic signed [ACC_W-1:0]   acc,
    input  logic signed [NUM_BIT-1:0] x,
    input  logic signed [NUM_BIT-1:0] w,
    output logic signed [ACC_W-1:0]   acc_next
);

    logic signed [2*NUM_BIT-1:0] product;

    always_comb begin
        product  = x * w;
        acc_next = acc + {{(ACC_W - 2*NUM_BIT){product[2*NUM_BIT-1]}}, product};
    end

endmodule

// File: rtl/neuron_ctrl.sv
// Sequential single-neuron evaluator: MAC over NUM_INPUTS pairs, add bias, saturate.
// Define NEURON_RELU_EN to apply a ReLU to the saturated result.
module neuron_ctrl
    import neuron_pkg::*;
#(
    parameter int NUM_BIT    = 16,
    parameter int NUM_INPUTS = 4,
    parameter int FRAC_BIT   = 8
) (
    input  logic           clk,
    input  logic           reset,
    neuron_ctrl_if.slave   bus
);

    localparam int AW    = addr_width(NUM_INPUTS);
    localparam int ACC_W = acc_width(NUM_BIT, NUM_INPUTS);
    localparam int SUM_W = sum_width(NUM_BIT, NUM_INPUTS);

    localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_INPUTS - 1);
    localparam logic signed [SUM_W-1:0] SAT_MAX =
        {{(SUM_W - NUM_BIT + 1){1'b0}}, {(NUM_BIT - 1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN =
        {{(SUM_W - NUM_BIT + 1){1'b1}}, {(NUM_BIT - 1){1'b0}}};

    state_t state;

    logic signed [ACC_W-1:0]   acc_q;
    logic signed [ACC_W-1:0]   acc_next;
    logic signed [ACC_W-1:0]   acc_d;
    logic                      acc_en;
    logic signed [ACC_W-1:0]   shifted;
    logic signed [SUM_W-1:0]   sum;
    logic signed [NUM_BIT-1:0] sat_val;
    logic signed [NUM_BIT-1:0] y_d;
    logic                      y_en;

    mac_unit #(
        .NUM_BIT (NUM_BIT),
        .ACC_W   (ACC_W)
    ) u_mac (
        .acc      (acc_q),
        .x        (bus.x_in),
        .w        (bus.w_in),
        .acc_next (acc_next)
    );

    // The accumulator is cleared on the accepting edge and then summed once per MAC cycle.
    always_comb begin
        acc_en = ((state == IDLE) && bus.start) || (state == MAC);
        acc_d  = (state == IDLE) ? '0 : acc_next;
    end

    Register #(
        .WIDTH (ACC_W)
    ) u_acc_reg (
        .clk   (clk),
        .reset (reset),
        .en    (acc_en),
        .d     (acc_d),
        .q     (acc_q)
    );

    // Arithmetic shift floors toward minus infinity before the widened bias add.
    always_comb begin
        shifted = acc_q >>> FRAC_BIT;
        sum     = {shifted[ACC_W-1], shifted}
                + {{(SUM_W - NUM_BIT){bus.bias[NUM_BIT-1]}}, bus.bias};
        if (sum > SAT_MAX)
            sat_val = SAT_MAX[NUM_BIT-1:0];
        else if (sum < SAT_MIN)
            sat_val = SAT_MIN[NUM_BIT-1:0];
        else
            sat_val = sum[NUM_BIT-1:0];
`ifdef NEURON_RELU_EN
        y_d = sat_val[NUM_BIT-1] ? '0 : sat_val;
`else
        y_d = sat_val;
`endif
        y_en = (state == BIAS);
    end

    Register #(
        .WIDTH (NUM_BIT)
    ) u_y_reg (
        .clk   (clk),
        .reset (reset),
        .en    (y_en),
        .d     (y_d),
        .q     (bus.y)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            bus.addr      <= '0;
            bus.busy      <= 1'b0;
            bus.out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.addr <= '0;
                    if (bus.start) begin
                        state    <= MAC;
                        bus.busy <= 1'b1;
                    end
                end
                MAC: begin
                    if (bus.addr == LAST_ADDR) begin
                        state    <= BIAS;
                        bus.addr <= '0;
                    end else begin
                        bus.addr <= bus.addr + 1'b1;
                    end
                end
                BIAS: begin
                    state         <= OUT;
                    bus.out_valid <= 1'b1;
                end
                OUT: begin
                    if (bus.out_ready) begin
                        state         <= IDLE;
                        bus.out_valid <= 1'b0;
                        bus.busy      <= 1'b0;
                    end
                end
                default: begin
                    state         <= IDLE;
                    bus.addr      <= '0;
                    bus.busy      <= 1'b0;
                    bus.out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_ctrl.sv
// Directed self-checking bench for neuron_ctrl (NUM_BIT=16, FRAC_BIT=8, NUM_INPUTS=4).
// Expected results follow the NEURON_RELU_EN setting of the build.
module tb_neuron_ctrl;

    localparam int NB = 16;
    localparam int NI = 4;
    localparam int FB = 8;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    neuron_ctrl_if #(.NUM_BIT(NB), .NUM_INPUTS(NI)) bus ();

    neuron_ctrl #(
        .NUM_BIT    (NB),
        .NUM_INPUTS (NI),
        .FRAC_BIT   (FB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic signed [NB-1:0] x_mem [NI];
    logic signed [NB-1:0] w_mem [NI];

    // Operand memories answer in the same cycle as the address.
    assign bus.x_in = x_mem[bus.addr];
    assign bus.w_in = w_mem[bus.addr];

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int xv[4], input int wv[4], input int bv);
        for (int i = 0; i < NI; i++) begin
            x_mem[i] = NB'(xv[i]);
            w_mem[i] = NB'(wv[i]);
        end
        bus.bias = NB'(bv);
    endtask

    // Latency counts edges after the start edge until out_valid is seen; -1 on timeout.
    task automatic startRun(output int latency);
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        latency = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                latency = c;
                break;
            end
        end
    endtask

    task automatic finishRun(input string tag);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        checkOutput({tag, "_done_busy"}, int'(bus.busy), 0);
        checkOutput({tag, "_done_valid"}, int'(bus.out_valid), 0);
    endtask

    task automatic runCase(input string tag, input int xv[4], input int wv[4],
                           input int bv, input int exp_y);
        int lat;
        applyStimulus(xv, wv, bv);
        startRun(lat);
        checkOutput({tag, "_latency"}, lat, 5);
        checkOutput({tag, "_y"}, int'(bus.y), exp_y);
        checkOutput({tag, "_busy"}, int'(bus.busy), 1);
        finishRun(tag);
    endtask

    initial begin
        int lat;
        int found;
        int held_y;

        reset         = 1'b1;
        bus.start     = 1'b1;
        bus.out_ready = 1'b0;
        bus.bias      = '0;
        for (int i = 0; i < NI; i++) begin
            x_mem[i] = '0;
            w_mem[i] = '0;
        end

        repeat (3) @(negedge clk);
        checkOutput("rst_busy", int'(bus.busy), 0);
        checkOutput("rst_valid", int'(bus.out_valid), 0);
        checkOutput("rst_addr", int'(bus.addr), 0);
        checkOutput("rst_y", int'(bus.y), 0);
        reset     = 1'b0;
        bus.start = 1'b0;

        runCase("pos_basic", '{256, 256, 256, 256}, '{128, 128, 128, 128}, 0, 512);
`ifdef NEURON_RELU_EN
        runCase("neg_basic", '{256, 256, 256, 256}, '{-128, -128, -128, -128}, 0, 0);
        runCase("sat_neg", '{32767, 32767, 32767, 32767}, '{-32768, -32768, -32768, -32768}, 100, 0);
        runCase("floor_neg", '{1, 1, 1, 1}, '{-1, -1, -1, -1}, 0, 0);
`else
        runCase("neg_basic", '{256, 256, 256, 256}, '{-128, -128, -128, -128}, 0, -512);
        runCase("sat_neg", '{32767, 32767, 32767, 32767}, '{-32768, -32768, -32768, -32768}, 100, -32768);
        runCase("floor_neg", '{1, 1, 1, 1}, '{-1, -1, -1, -1}, 0, -1);
`endif
        runCase("sat_pos", '{32767, 32767, 32767, 32767}, '{32767, 32767, 32767, 32767}, 100, 32767);
        runCase("floor_pos", '{1, 1, 1, 1}, '{1, 1, 1, 1}, 3, 3);
        runCase("mixed", '{256, 512, -256, 768}, '{256, -128, 64, 32}, 10, 42);

        // Consumer stalls in OUT while start is pulsed.
        applyStimulus('{256, 256, 256, 256}, '{128, 128, 128, 128}, 0);
        startRun(lat);
        checkOutput("hold_latency", lat, 5);
        held_y = 512;
        for (int i = 0; i < 5; i++) begin
            bus.start = (i == 1);
            @(negedge clk);
            checkOutput($sformatf("hold_y_%0d", i), int'(bus.y), held_y);
            checkOutput($sformatf("hold_valid_%0d", i), int'(bus.out_valid), 1);
            checkOutput($sformatf("hold_busy_%0d", i), int'(bus.busy), 1);
        end
        bus.start     = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.start     = 1'b0;
        bus.out_ready = 1'b0;
        checkOutput("hold_done_busy", int'(bus.busy), 0);
        checkOutput("hold_done_valid", int'(bus.out_valid), 0);
        @(negedge clk);
        checkOutput("hold_no_restart", int'(bus.busy), 0);

        // Reset mid-MAC, with start asserted alongside it.
        applyStimulus('{256, 256, 256, 256}, '{128, 128, 128, 128}, 0);
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        found = -1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (bus.addr == 2'd2) begin
                found = c;
                break;
            end
        end
        checkOutput("mid_addr_cycle", found, 2);
        reset     = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        reset     = 1'b0;
        bus.start = 1'b0;
        checkOutput("midrst_busy", int'(bus.busy), 0);
        checkOutput("midrst_valid", int'(bus.out_valid), 0);
        checkOutput("midrst_addr", int'(bus.addr), 0);
        checkOutput("midrst_y", int'(bus.y), 0);
        @(negedge clk);
        checkOutput("midrst_idle", int'(bus.busy), 0);
        runCase("after_rst", '{256, 256, 256, 256}, '{128, 128, 128, 128}, 0, 512);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/neuron_ctrl.md
NEURON_CTRL -- requirements
Module: neuron_ctrl

Interface
REQ-001 Parameter NUM_BIT, default 16: signed data width of inputs, weights, bias and result.
REQ-002 Parameter NUM_INPUTS, default 4: inputs per neuron evaluation, legal 2..255.
REQ-003 Parameter FRAC_BIT, default 8: fractional bits of the Q-format operands.
REQ-004 clk  input  1  single clock; all state changes on posedge clk.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  request one neuron evaluation; sampled only in IDLE.
REQ-007 busy  output  1  high in every state except IDLE.
REQ-008 addr  output  $clog2(NUM_INPUTS)  index of the input/weight pair being fetched.
REQ-009 x_in  input  NUM_BIT  signed input value at addr, valid in the same cycle.
REQ-010 w_in  input  NUM_BIT  signed weight at addr, valid in the same cycle.
REQ-011 bias  input  NUM_BIT  signed bias, sampled in state BIAS.
REQ-012 y  output  NUM_BIT  signed neuron result.
REQ-013 out_valid  output  1  y is valid.
REQ-014 out_ready  input  1  consumer accepts y.

Function
REQ-015 FSM states: IDLE, MAC, BIAS, OUT.
REQ-016 IDLE -> MAC when start=1; addr=0, accumulator cleared in the same edge.
REQ-017 MAC: each cycle, acc <= acc + x_in*w_in, addr increments; after addr=NUM_INPUTS-1 is consumed -> BIAS.
REQ-018 BIAS: y <= sat((acc >>> FRAC_BIT) + bias) -> OUT (one cycle).
REQ-019 OUT: out_valid=1; y, out_valid held stable while out_ready=0; out_valid && out_ready -> IDLE.
REQ-020 Latency: start sampled at edge 0 -> out_valid high from edge NUM_INPUTS+1.
REQ-021 Products are full 2*NUM_BIT signed; accumulator is 2*NUM_BIT+$clog2(NUM_INPUTS)+1 bits and never overflows.
REQ-022 >>> is arithmetic (round toward minus infinity); sat clamps to [-2^(NUM_BIT-1), 2^(NUM_BIT-1)-1].
REQ-023 start outside IDLE, including the OUT cycle of transfer completion, is ignored.
REQ-024 addr holds 0 in IDLE, BIAS and OUT; never exceeds NUM_INPUTS-1.

Reset
REQ-025 reset=1 at a clock edge forces IDLE from any state, including mid-MAC or OUT with a pending transfer.
REQ-026 Reset values: busy=0, out_valid=0, addr=0, y=0, accumulator=0.
REQ-027 reset has priority over start and out_ready in the same cycle.

Configuration
REQ-028 Macro NEURON_RELU_EN defined: result in BIAS is max(0, sat(...)) (ReLU).
REQ-029 NEURON_RELU_EN undefined: result is sat(...) unchanged (identity activation); timing identical in both builds.

Structure
REQ-030 Shared package neuron_pkg holds the state enum type and the saturation/width helper constants.
REQ-031 One sub-module, mac_unit: combinational signed multiply-add producing the next accumulator value.
REQ-032 y and accumulator storage use the existing parameterised Register block with reset tied to reset.

Verification (NUM_BIT=16, FRAC_BIT=8, NUM_INPUTS=4)
REQ-033 x=256, w=128 all four, bias=0, start at edge 0 -> out_valid at edge 5, y=512.
REQ-034 x=256, w=-128 all, bias=0 -> y=-512 without NEURON_RELU_EN, y=0 with it.
REQ-035 x=32767, w=32767 all, bias=100 -> y=32767 (positive saturation); w=-32768 -> y=-32768 (no ReLU).
REQ-036 out_ready low 5 cycles in OUT with start pulsed -> y, out_valid stable, busy=1, no new run; out_ready=1 -> IDLE next edge.
REQ-037 reset asserted while addr=2 -> next edge busy=0, out_valid=0, addr=0; fresh start gives REQ-033 result.
